reg_bridge: RTL

Avalon-MM slave to reg_mux CPU-side bridge. Sits directly upstream of the register multiplexer: accepts single-word register accesses from the PCIe BAR Avalon-MM master, drives the multiplexer's channel, write and read handshakes, and returns read data. It holds the channel stable for the whole transaction and bounds every access with a timeout so a dead region cannot hang the host.

---
 rtl/reg_bridge.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/reg_bridge.sv
`timescale 1ns/1ps
// Avalon-MM slave bridging single-word register accesses onto the reg_mux
// CPU-side channel/write/read handshakes, with a per-access timeout.
module reg_bridge #(
    parameter  int NUM_RGNS = 4,
    parameter  int TIMEOUT  = 255,
    localparam int CW       = (NUM_RGNS > 1) ? $clog2(NUM_RGNS) : 1
) (
    input  logic          sysClk_in,
    input  logic          sysRstN_in,
    input  logic [CW-1:0] avAddr_in,
    input  logic [31:0]   avWrData_in,
    input  logic          avWrite_in,
    input  logic          avRead_in,
    output logic          avWaitReq_out,
    output logic [31:0]   avRdData_out,
    output logic          avRdValid_out,
    output logic [CW-1:0] cpuChan_out,
    output logic [31:0]   cpuWrData_out,
    output logic          cpuWrValid_out,
    input  logic          cpuWrReady_in,
    input  logic [31:0]   cpuRdData_in,
    input  logic          cpuRdValid_in,
    output logic          cpuRdReady_out,
    output logic          timeoutErr_out,
    input  logic          errClear_in
);

    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [31:0] OOR_DATA = 32'hFFFF_FFFF;
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          wr_valid_q, wr_valid_d;
    logic          rd_ready_q, rd_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;

    logic in_range;
    logic timeout;

    assign in_range = (32'(avAddr_in) < 32'(NUM_RGNS));
    // The last waiting cycle is the one where the counter holds TIMEOUT-1.
    assign timeout  = (TIMEOUT != 0) && (cnt_q == TW'(TLAST));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wr_valid_d = 1'b0;
        rd_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = errClear_in ? 1'b0 : err_q;

        unique case (state_q)
            IDLE: begin
                if (avWrite_in) begin
                    chan_d  = avAddr_in;
                    wdata_d = avWrData_in;
                    if (in_range) begin
                        state_d    = WRITE;
                        wr_valid_d = 1'b1;
                        cnt_d      = '0;
                    end
                end else if (avRead_in) begin
                    chan_d = avAddr_in;
                    if (in_range) begin
                        state_d    = READ;
                        rd_ready_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d    = RESP;
                        rd_valid_d = 1'b1;
                        rdata_d    = OOR_DATA;
                    end
                end
            end
            WRITE: begin
                if (cpuWrReady_in) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wr_valid_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            READ: begin
                if (cpuRdValid_in) begin
                    state_d    = RESP;
                    rd_valid_d = 1'b1;
                    rdata_d    = cpuRdData_in;
                end else if (timeout) begin
                    state_d    = RESP;
                    rd_valid_d = 1'b1;
                    rdata_d    = TMO_DATA;
                    err_d      = 1'b1;
                end else begin
                    rd_ready_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chan_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_valid_q <= wr_valid_d;
            rd_ready_q <= rd_ready_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign avWaitReq_out  = (state_q != IDLE);
    assign avRdData_out   = rdata_q;
    assign avRdValid_out  = rd_valid_q;
    assign cpuChan_out    = chan_q;
    assign cpuWrData_out  = wdata_q;
    assign cpuWrValid_out = wr_valid_q;
    assign cpuRdReady_out = rd_ready_q;
    assign timeoutErr_out = err_q;

endmodule
